// File: rtl/arbitro_rr_fifo_pkg.sv
// Shared definitions for the round-robin input-to-output FIFO scheduler.
// Word geometry, FSM encoding, the in-flight slot record and small helpers.
// Imported by the interface, the priority selector and the top level.
package arbitro_rr_fifo_pkg;

    localparam int DATA_W   = 10;
    localparam int N_IN     = 4;
    localparam int N_OUT    = 4;
    localparam int DEST_MSB = 9;
    localparam int DEST_LSB = DEST_MSB - 1;
    localparam int DEST_W   = 2;
    localparam int IDX_W    = $clog2(N_IN);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Word registered at the grant edge and pushed in the following cycle.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  id;
        logic [DEST_W-1:0] dest;
    } slot_t;

    function automatic logic [DEST_W-1:0] get_dest(input logic [DATA_W-1:0] word);
        return word[DEST_MSB:DEST_LSB];
    endfunction

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (int'(idx) == N_IN - 1) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/arbitro_rr_fifo_if.sv
// Bundle of the input-FIFO head/pop side and the output-FIFO push/afull side.
// slave: scheduler view (consumes heads, drives pops/pushes); master: environment view.
// Ports: arb_en, in_empty, in_data, in_pop, out_afull, out_push, out_data, grant_id, idle.
interface arbitro_rr_fifo_if;
    import arbitro_rr_fifo_pkg::*;

    logic                   arb_en;
    logic [N_IN-1:0]        in_empty;
    logic [N_IN*DATA_W-1:0] in_data;
    logic [N_IN-1:0]        in_pop;
    logic [N_OUT-1:0]       out_afull;
    logic [N_OUT-1:0]       out_push;
    logic [DATA_W-1:0]      out_data;
    logic [IDX_W-1:0]       grant_id;
    logic                   idle;

    modport slave (
        input  arb_en, in_empty, in_data, out_afull,
        output in_pop, out_push, out_data, grant_id, idle
    );

    modport master (
        output arb_en, in_empty, in_data, out_afull,
        input  in_pop, out_push, out_data, grant_id, idle
    );

endinterface

// File: rtl/arbitro_rr_fifo_prioridad.sv
// Rotating-priority selector: first asserted request at or after ptr wins.
// Latency: purely combinational.
// Backpressure: none here; callers mask blocked requesters out of req.
// Ports: req (request vector), ptr (highest-priority index),
//        gnt (one-hot or zero), gnt_idx (encoded winner), gnt_vld (any winner).
module rr_prioridad
    import arbitro_rr_fifo_pkg::*;
(
    input  logic [N_IN-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_IN-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int k = 0; k < N_IN; k++) begin
            idx = IDX_W'((int'(ptr) + k) % N_IN);
            if (!gnt_vld && req[idx]) begin
                gnt_vld      = 1'b1;
                gnt_idx      = idx;
                gnt[idx]     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_fifo.sv
// Round-robin scheduler moving head words from 4 input FIFOs to 4 output FIFOs.
// Latency: pop in cycle N, push of the registered word in cycle N+1; 1 word/cycle.
// Backpressure: inputs whose destination is almost-full are skipped, others proceed.
// Ports: clk, reset (async active-low), bus (slave modport of arbitro_rr_fifo_if).
module arbitro_rr_fifo
    import arbitro_rr_fifo_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    arbitro_rr_fifo_if.slave bus
);

    logic [DATA_W-1:0] head [N_IN];
    logic [N_IN-1:0]   elig;
    logic [N_IN-1:0]   gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_vld;

    arb_state_e        fsm_q, fsm_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    slot_t             slot_q, slot_d;

    // Eligibility is also gated by reset so no pop escapes while the
    // registers are held, even though the selector is combinational.
    always_comb begin
        elig = '0;
        for (int i = 0; i < N_IN; i++) begin
            head[i] = bus.in_data[i*DATA_W +: DATA_W];
            elig[i] = reset & bus.arb_en & ~bus.in_empty[i]
                    & ~bus.out_afull[get_dest(head[i])];
        end
    end

    rr_prioridad u_prioridad (
        .req     (elig),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    // A grant always (re)loads the slot, so BUSY->BUSY needs no stall.
    always_comb begin
        fsm_d  = gnt_vld ? BUSY : IDLE;
        ptr_d  = ptr_q;
        slot_d = slot_q;
        if (gnt_vld) begin
            ptr_d       = next_idx(gnt_idx);
            slot_d.data = head[gnt_idx];
            slot_d.id   = gnt_idx;
            slot_d.dest = get_dest(head[gnt_idx]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm_q  <= IDLE;
            ptr_q  <= '0;
            slot_q <= '0;
        end else begin
            fsm_q  <= fsm_d;
            ptr_q  <= ptr_d;
            slot_q <= slot_d;
        end
    end

    // Push is decoded from registered state only, so the async reset
    // removes it immediately and drops any word in flight.
    always_comb begin
        bus.out_push = '0;
        if (fsm_q == BUSY) begin
            bus.out_push[slot_q.dest] = 1'b1;
        end
    end

    assign bus.in_pop   = gnt;
    assign bus.out_data = slot_q.data;
    assign bus.grant_id = slot_q.id;
    assign bus.idle     = (fsm_q == IDLE) && (elig == '0);

endmodule

// File: tb/tb_arbitro_rr_fifo.sv
// Bench for arbitro_rr_fifo: FIFO models on the input side, a scoreboard of
// expected pushes, a monitor comparing every push, plus directed cycle checks.
module tb_arbitro_rr_fifo;

    typedef struct {
        logic [3:0] push;
        logic [9:0] data;
        logic [1:0] id;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    logic [9:0] fq [4][$];
    exp_t       exp_q [$];
    logic [3:0] pop_s;

    arbitro_rr_fifo_if bus();

    arbitro_rr_fifo dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            bus.in_empty[i]          = (fq[i].size() == 0);
            bus.in_data[i*10 +: 10]  = (fq[i].size() == 0) ? 10'h000 : fq[i][0];
        end
    endtask

    task automatic load(input int i, input logic [9:0] w);
        fq[i].push_back(w);
        refresh();
    endtask

    task automatic expect_push(input logic [3:0] p, input logic [9:0] d, input logic [1:0] id);
        exp_t e;
        e.push = p;
        e.data = d;
        e.id   = id;
        exp_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // First-word-fall-through input FIFO model: pops sampled mid-cycle,
    // applied just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            pop_s = bus.in_pop;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (pop_s[i] && fq[i].size() > 0) begin
                    void'(fq[i].pop_front());
                end
            end
            refresh();
        end
    end

    // Push monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.out_push != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_push actual=%0h data=%0h required=none at %0t",
                             bus.out_push, bus.out_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_push_vec", 32'(bus.out_push), 32'(e.push));
                    check("sb_out_data", 32'(bus.out_data), 32'(e.data));
                    check("sb_grant_id", 32'(bus.grant_id), 32'(e.id));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.arb_en    = 1'b1;
        bus.out_afull = 4'b0000;
        bus.in_empty  = 4'b1111;
        bus.in_data   = '0;
        refresh();

        // Reset with all inputs non-empty; fairness words (dest 0).
        for (int i = 0; i < 4; i++) load(i, 10'h010 + 10'(i));
        for (int i = 0; i < 4; i++) load(i, 10'h020 + 10'(i));
        for (int k = 0; k < 8; k++) begin
            logic [9:0] w;
            w = (k < 4) ? (10'h010 + 10'(k)) : (10'h020 + 10'(k - 4));
            expect_push(4'b0001, w, 2'(k % 4));
        end
        cyc();
        cyc();
        #1;
        check("rst_in_pop",   32'(bus.in_pop),   32'h0);
        check("rst_out_push", 32'(bus.out_push), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_grant_id", 32'(bus.grant_id), 32'h0);
        check("rst_idle",     32'(bus.idle),     32'h1);
        cyc();
        reset = 1'b1;

        // Fairness: 0,1,2,3,0,1,2,3 back-to-back, push[0] high 8 cycles.
        for (int k = 0; k < 8; k++) begin
            #1;
            check("fair_pop_order", 32'(bus.in_pop), 32'(4'b0001 << (k % 4)));
            check("fair_push", 32'(bus.out_push), (k == 0) ? 32'h0 : 32'h1);
            cyc();
        end
        #1;
        check("fair_push_last", 32'(bus.out_push), 32'h1);
        cyc();
        #1;
        check("fair_push_end", 32'(bus.out_push), 32'h0);
        check("fair_idle",     32'(bus.idle),     32'h1);

        // Routing and latency: FIFO2 -> dest 3.
        cyc();
        load(2, 10'b11_0101_0101);
        expect_push(4'b1000, 10'h355, 2'd2);
        #1;
        check("route_pop", 32'(bus.in_pop), 32'h4);
        cyc();
        #1;
        check("route_push",     32'(bus.out_push), 32'h8);
        check("route_data",     32'(bus.out_data), 32'h355);
        check("route_grant_id", 32'(bus.grant_id), 32'h2);
        check("route_no_pop",   32'(bus.in_pop),   32'h0);
        cyc();
        #1;
        check("route_idle", 32'(bus.idle), 32'h1);

        // Backpressure bypass: ptr=3, FIFO0->dest1 blocked, FIFO1->dest2 ok.
        cyc();
        bus.out_afull = 4'b0010;
        load(0, 10'h101);
        load(1, 10'h202);
        expect_push(4'b0100, 10'h202, 2'd1);
        expect_push(4'b0010, 10'h101, 2'd0);
        #1;
        check("bp_skip_pop", 32'(bus.in_pop), 32'h2);
        cyc();
        #1;
        check("bp_blocked_pop", 32'(bus.in_pop),   32'h0);
        check("bp_push",        32'(bus.out_push), 32'h4);
        check("bp_busy_idle",   32'(bus.idle),     32'h0);
        cyc();
        bus.out_afull = 4'b0000;
        #1;
        check("bp_release_pop", 32'(bus.in_pop), 32'h1);
        cyc();
        cyc();
        #1;
        check("bp_idle", 32'(bus.idle), 32'h1);

        // arb_en drop at the edge ending a grant: word still pushed, then none.
        cyc();
        load(1, 10'h0AA);
        load(2, 10'h0BB);
        expect_push(4'b0001, 10'h0AA, 2'd1);
        expect_push(4'b0001, 10'h0BB, 2'd2);
        #1;
        check("en_pop", 32'(bus.in_pop), 32'h2);
        cyc();
        bus.arb_en = 1'b0;
        #1;
        check("en_inflight_push", 32'(bus.out_push), 32'h1);
        check("en_off_pop",       32'(bus.in_pop),   32'h0);
        cyc();
        #1;
        check("en_off_push", 32'(bus.out_push), 32'h0);
        check("en_off_idle", 32'(bus.idle),     32'h1);
        cyc();
        #1;
        check("en_off_pop2", 32'(bus.in_pop), 32'h0);
        bus.arb_en = 1'b1;
        #1;
        check("en_on_pop", 32'(bus.in_pop), 32'h4);
        cyc();
        cyc();
        #1;
        check("en_idle", 32'(bus.idle), 32'h1);

        // Reset during BUSY: push removed asynchronously, word discarded.
        cyc();
        load(3, 10'h3C3);
        #1;
        check("mid_pop", 32'(bus.in_pop), 32'h8);
        cyc();
        check("mid_busy_push", 32'(bus.out_push), 32'h8);
        #1;
        reset = 1'b0;
        #1;
        check("mid_async_push", 32'(bus.out_push), 32'h0);
        check("mid_async_data", 32'(bus.out_data), 32'h0);
        check("mid_async_idle", 32'(bus.idle),     32'h1);
        cyc();
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("mid_no_delivery", 32'(bus.out_push), 32'h0);
            cyc();
        end

        check("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
